// File: rtl/gol_gen_scheduler.sv
// -----------------------------------------------------------------------------
// gol_gen_scheduler
//   Sequences Game-of-Life generations on a 7x7 grid. In RUN mode, a new
//   generation starts after a programmable idle period. In PAUSE mode, each
//   step rising edge starts one generation. A generation is computed by
//   scanning a latched snapshot one cell per cycle. Results are collected in a
//   shadow buffer, and the buffer is published in a single commit cycle.
//
// Ports
//   clka        sole clock, rising edge
//   rst_n       synchronous active-low reset
//   game_state  00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE
//   step        single-step request (rising edge, PAUSE only)
//   period      idle cycles between generations in RUN
//   grid_in     current grid, bit r*7+c = row r, column c, 1 = alive
//   busy        high during the 49-cycle scan
//   cell_idx    cell under evaluation (0 outside the scan)
//   commit      one-cycle pulse, grid_next holds a new generation
//   grid_next   most recently committed generation
//   gen_count   committed generations (wraps)
//   stable      last generation equals its predecessor
//   extinct     last generation has no live cells
// -----------------------------------------------------------------------------
module gol_gen_scheduler #(
    parameter int GEN_W = 16,
    parameter int PER_W = 8
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic [1:0]       game_state,
    input  logic             step,
    input  logic [PER_W-1:0] period,
    input  logic [48:0]      grid_in,
    output logic             busy,
    output logic [5:0]       cell_idx,
    output logic             commit,
    output logic [48:0]      grid_next,
    output logic [GEN_W-1:0] gen_count,
    output logic             stable,
    output logic             extinct
);

    localparam logic [1:0] MODE_IDLE    = 2'b00;
    localparam logic [1:0] MODE_PROGRAM = 2'b01;
    localparam logic [1:0] MODE_RUN     = 2'b10;
    localparam logic [1:0] MODE_PAUSE   = 2'b11;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t           state_r;
    logic [PER_W-1:0] wait_cnt_r;
    logic             step_prev_r;
    logic [48:0]      snapshot_r;
    logic [48:0]      shadow_r;
    logic [2:0]       row_r;
    logic [2:0]       col_r;

    logic             start_s;
    logic             has_n_s;
    logic             has_s_s;
    logic             has_w_s;
    logic             has_e_s;
    logic [6:0]       idx_s;
    logic [7:0]       nb_s;
    logic [3:0]       nbr_cnt_s;
    logic             alive_s;
    logic [48:0]      shadow_nxt_s;

    // This helper reads a snapshot cell. Indices past the grid read as dead.
    function automatic logic cell_at(input logic [48:0] g, input logic [6:0] i);
        logic v;
        if (i < 7'd49) begin
            v = g[i[5:0]];
        end else begin
            v = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        return {3'b000, v[0]} + {3'b000, v[1]} + {3'b000, v[2]} + {3'b000, v[3]}
             + {3'b000, v[4]} + {3'b000, v[5]} + {3'b000, v[6]} + {3'b000, v[7]};
    endfunction

    // Start condition: the RUN period has elapsed, or a fresh step edge arrives in PAUSE.
    always_comb begin
        start_s = 1'b0;
        if (game_state == MODE_RUN) begin
            start_s = (wait_cnt_r >= period);
        end else if (game_state == MODE_PAUSE) begin
            start_s = step & ~step_prev_r;
        end else begin
            start_s = 1'b0;
        end
    end

    // Neighbour gather for the current cell. Row/column edge flags stop wrap-around.
    always_comb begin
        has_n_s = (row_r != 3'd0);
        has_s_s = (row_r != 3'd6);
        has_w_s = (col_r != 3'd0);
        has_e_s = (col_r != 3'd6);
        idx_s   = {1'b0, cell_idx};
        nb_s[0] = has_n_s & has_w_s & cell_at(snapshot_r, idx_s - 7'd8);
        nb_s[1] = has_n_s           & cell_at(snapshot_r, idx_s - 7'd7);
        nb_s[2] = has_n_s & has_e_s & cell_at(snapshot_r, idx_s - 7'd6);
        nb_s[3] = has_w_s           & cell_at(snapshot_r, idx_s - 7'd1);
        nb_s[4] = has_e_s           & cell_at(snapshot_r, idx_s + 7'd1);
        nb_s[5] = has_s_s & has_w_s & cell_at(snapshot_r, idx_s + 7'd6);
        nb_s[6] = has_s_s           & cell_at(snapshot_r, idx_s + 7'd7);
        nb_s[7] = has_s_s & has_e_s & cell_at(snapshot_r, idx_s + 7'd8);
        nbr_cnt_s = popcount8(nb_s);
    end

    // Life rule for the current cell. The result is merged into the shadow
    // buffer so that the final cell can be published in the same edge.
    always_comb begin
        alive_s = (nbr_cnt_s == 4'd3) | (snapshot_r[cell_idx] & (nbr_cnt_s == 4'd2));
        shadow_nxt_s = shadow_r;
        shadow_nxt_s[cell_idx] = alive_s;
    end

    // Scheduler FSM together with its registered outputs.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_r     <= ST_WAIT;
            wait_cnt_r  <= {PER_W{1'b0}};
            step_prev_r <= 1'b0;
            snapshot_r  <= 49'd0;
            shadow_r    <= 49'd0;
            row_r       <= 3'd0;
            col_r       <= 3'd0;
            busy        <= 1'b0;
            cell_idx    <= 6'd0;
            commit      <= 1'b0;
            grid_next   <= 49'd0;
            gen_count   <= {GEN_W{1'b0}};
            stable      <= 1'b0;
            extinct     <= 1'b0;
        end else begin
            step_prev_r <= step;
            commit      <= 1'b0;
            if ((game_state == MODE_IDLE) || (game_state == MODE_PROGRAM)) begin
                // Leaving play mode abandons any scan. The last published grid stays.
                state_r    <= ST_WAIT;
                wait_cnt_r <= {PER_W{1'b0}};
                row_r      <= 3'd0;
                col_r      <= 3'd0;
                busy       <= 1'b0;
                cell_idx   <= 6'd0;
                gen_count  <= {GEN_W{1'b0}};
                stable     <= 1'b0;
                extinct    <= 1'b0;
            end else begin
                case (state_r)
                    ST_WAIT: begin
                        if (start_s) begin
                            state_r    <= ST_SCAN;
                            snapshot_r <= grid_in;
                            shadow_r   <= 49'd0;
                            wait_cnt_r <= {PER_W{1'b0}};
                            row_r      <= 3'd0;
                            col_r      <= 3'd0;
                            busy       <= 1'b1;
                            cell_idx   <= 6'd0;
                        end else if (wait_cnt_r != {PER_W{1'b1}}) begin
                            wait_cnt_r <= wait_cnt_r + {{(PER_W-1){1'b0}}, 1'b1};
                        end else begin
                            // Saturate, so that a long PAUSE cannot wrap past period.
                            wait_cnt_r <= wait_cnt_r;
                        end
                    end
                    ST_SCAN: begin
                        shadow_r <= shadow_nxt_s;
                        if (cell_idx == 6'd48) begin
                            state_r   <= ST_COMMIT;
                            busy      <= 1'b0;
                            cell_idx  <= 6'd0;
                            row_r     <= 3'd0;
                            col_r     <= 3'd0;
                            commit    <= 1'b1;
                            grid_next <= shadow_nxt_s;
                            gen_count <= gen_count + {{(GEN_W-1){1'b0}}, 1'b1};
                            stable    <= (shadow_nxt_s == snapshot_r);
                            extinct   <= (shadow_nxt_s == 49'd0);
                        end else begin
                            cell_idx <= cell_idx + 6'd1;
                            if (col_r == 3'd6) begin
                                col_r <= 3'd0;
                                row_r <= row_r + 3'd1;
                            end else begin
                                col_r <= col_r + 3'd1;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= {PER_W{1'b0}};
                    end
                    default: begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= {PER_W{1'b0}};
                        busy       <= 1'b0;
                        cell_idx   <= 6'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gol_gen_scheduler
//   Directed sequence with randomized grids. Every expected grid comes from a
//   plain 2-D Game-of-Life reference model. Timing expectations follow the
//   scheduling rules: the generation spacing in RUN is period+51 cycles, and
//   a step edge in PAUSE yields one generation.
// -----------------------------------------------------------------------------
module tb_gol_gen_scheduler;

    logic        clka = 1'b0;
    logic        rst_n;
    logic [1:0]  game_state;
    logic        step;
    logic [7:0]  period;
    logic [48:0] grid_in;
    logic        busy;
    logic [5:0]  cell_idx;
    logic        commit;
    logic [48:0] grid_next;
    logic [15:0] gen_count;
    logic        stable;
    logic        extinct;

    int tests_run = 0;
    int fails     = 0;

    gol_gen_scheduler #(.GEN_W(16), .PER_W(8)) dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .game_state (game_state),
        .step       (step),
        .period     (period),
        .grid_in    (grid_in),
        .busy       (busy),
        .cell_idx   (cell_idx),
        .commit     (commit),
        .grid_next  (grid_next),
        .gen_count  (gen_count),
        .stable     (stable),
        .extinct    (extinct)
    );

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: count the live cells in the 3x3 window, clipped at the grid border.
    function automatic logic [48:0] life(input logic [48:0] g);
        logic [48:0] nx;
        logic [5:0]  bi;
        int cnt;
        nx = 49'd0;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 7 &&
                            (c + dc) >= 0 && (c + dc) < 7) begin
                            bi = 6'((r + dr) * 7 + (c + dc));
                            if (g[bi]) cnt++;
                        end
                    end
                end
                bi = 6'(r * 7 + c);
                nx[bi] = (cnt == 3) || (g[bi] && cnt == 2);
            end
        end
        return nx;
    endfunction

    // Wait for a commit and check the scan order and the hold on grid_next on the way.
    // grid_in is scrambled in the middle of the scan, so a late change must not leak in.
    task automatic wait_commit(input int budget, input int pos0, output int n);
        int          pos;
        bit          seen;
        logic [48:0] held;
        pos  = pos0;
        n    = 0;
        seen = 1'b0;
        held = grid_next;
        while (!seen && n < budget) begin
            @(negedge clka);
            n++;
            if (commit) begin
                seen = 1'b1;
            end else if (busy) begin
                check("scan_idx", 64'(cell_idx), 64'(pos));
                check("scan_hold", 64'(grid_next), 64'(held));
                if (pos == 20) grid_in = 49'({$urandom(), $urandom()});
                pos++;
            end
        end
        check("commit_seen", 64'(seen), 64'd1);
        if (seen) check("scan_len", 64'(pos), 64'd49);
    endtask

    initial begin
        int          n;
        int          pulses;
        bit          found;
        logic [48:0] g;
        logic [48:0] exp_g;
        logic [48:0] saved;
        logic [15:0] exp_gen;

        rst_n      = 1'b0;
        game_state = 2'b10;
        period     = 8'd0;
        step       = 1'b0;
        grid_in    = 49'h3800000;
        repeat (3) @(negedge clka);
        check("rst_busy",     64'(busy),      64'd0);
        check("rst_cell_idx", 64'(cell_idx),  64'd0);
        check("rst_commit",   64'(commit),    64'd0);
        check("rst_grid",     64'(grid_next), 64'd0);
        check("rst_gen",      64'(gen_count), 64'd0);
        check("rst_stable",   64'(stable),    64'd0);
        check("rst_extinct",  64'(extinct),   64'd0);

        // Blinker in RUN with period 0. The release cycle counts as cycle 1,
        // so a commit in cycle 51 is seen at the 50th negedge after release.
        rst_n = 1'b1;
        wait_commit(200, 0, n);
        check("blinker_latency", 64'(n),         64'd50);
        check("blinker_grid",    64'(grid_next), 64'h0_8102_0000);
        check("blinker_model",   64'(grid_next), 64'(life(49'h3800000)));
        check("blinker_stable",  64'(stable),    64'd0);
        check("blinker_extinct", 64'(extinct),   64'd0);
        check("blinker_gen",     64'(gen_count), 64'd1);
        grid_in = life(49'h3800000);
        wait_commit(200, 0, n);
        check("p0_spacing",   64'(n),         64'd51);
        check("blinker2_grid", 64'(grid_next), 64'h3800000);
        check("blinker2_gen",  64'(gen_count), 64'd2);
        saved = 49'h3800000;

        // PROGRAM clears the counters and leaves grid_next untouched.
        game_state = 2'b01;
        @(negedge clka);
        check("prog_gen",    64'(gen_count), 64'd0);
        check("prog_stable", 64'(stable),    64'd0);
        check("prog_busy",   64'(busy),      64'd0);
        check("prog_grid",   64'(grid_next), 64'(saved));

        // RUN with period 9 over still, lone-cell and random grids.
        exp_gen    = 16'd0;
        period     = 8'd9;
        game_state = 2'b10;
        for (int i = 0; i < 6; i++) begin
            if (i < 2)       g = 49'h183;
            else if (i == 2) g = 49'd1 << 24;
            else             g = 49'({$urandom(), $urandom()}) & 49'({$urandom(), $urandom()} | {$urandom(), $urandom()});
            grid_in = g;
            exp_g   = life(g);
            wait_commit(300, 0, n);
            exp_gen = exp_gen + 16'd1;
            if (i > 0) check("p9_spacing", 64'(n), 64'd60);
            check("run_grid",    64'(grid_next), 64'(exp_g));
            check("run_stable",  64'(stable),    64'(exp_g == g));
            check("run_extinct", 64'(extinct),   64'(exp_g == 49'd0));
            check("run_gen",     64'(gen_count), 64'(exp_gen));
        end

        // PAUSE: step held high for 100 cycles gives exactly one generation (glider).
        game_state = 2'b11;
        grid_in    = 49'h1C202;
        repeat (5) @(negedge clka);
        pulses = 0;
        step   = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clka);
            if (commit) pulses++;
        end
        step    = 1'b0;
        exp_gen = exp_gen + 16'd1;
        check("step_pulses", 64'(pulses),    64'd1);
        check("step_gen",    64'(gen_count), 64'(exp_gen));
        check("step_grid",   64'(grid_next), 64'(life(49'h1C202)));

        // Switching RUN to PAUSE mid-scan still completes the generation.
        g          = 49'({$urandom(), $urandom()});
        grid_in    = g;
        period     = 8'd0;
        game_state = 2'b10;
        found      = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clka);
            if (busy) found = 1'b1;
        end
        check("pause_scan_started", 64'(found), 64'd1);
        game_state = 2'b11;
        wait_commit(100, 1, n);
        exp_gen = exp_gen + 16'd1;
        check("pause_mid_grid", 64'(grid_next), 64'(life(g)));
        check("pause_mid_gen",  64'(gen_count), 64'(exp_gen));
        saved = life(g);

        // Abort at cell 20 by going back to PROGRAM.
        game_state = 2'b01;
        @(negedge clka);
        grid_in    = 49'({$urandom(), $urandom()});
        game_state = 2'b10;
        found      = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clka);
            if (busy && cell_idx == 6'd20) found = 1'b1;
        end
        check("abort_reached_20", 64'(found), 64'd1);
        game_state = 2'b01;
        @(negedge clka);
        check("abort_busy",   64'(busy),      64'd0);
        check("abort_commit", 64'(commit),    64'd0);
        check("abort_idx",    64'(cell_idx),  64'd0);
        check("abort_gen",    64'(gen_count), 64'd0);
        check("abort_grid",   64'(grid_next), 64'(saved));
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clka);
            if (commit) pulses++;
        end
        check("abort_no_commit", 64'(pulses), 64'd0);

        // Reset during a scan aborts it without a commit.
        game_state = 2'b10;
        found      = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clka);
            if (busy && cell_idx == 6'd5) found = 1'b1;
        end
        check("rst_scan_started", 64'(found), 64'd1);
        rst_n = 1'b0;
        @(negedge clka);
        check("midrst_busy",   64'(busy),      64'd0);
        check("midrst_commit", 64'(commit),    64'd0);
        check("midrst_grid",   64'(grid_next), 64'd0);
        check("midrst_idx",    64'(cell_idx),  64'd0);
        rst_n = 1'b1;
        @(negedge clka);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/gol_gen_scheduler.md
GOL_GEN_SCHEDULER -- requirements
Module: gol_gen_scheduler

Interface
REQ-001 Parameter GEN_W, default 16: width of the generation counter.
REQ-002 Parameter PER_W, default 8: width of the inter-generation period input.
REQ-003 clka  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 game_state  input  2  game mode from the game FSM: 00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE.
REQ-006 step  input  1  single-step request; only its rising edge is used.
REQ-007 period  input  PER_W  idle cycles between generations in RUN.
REQ-008 grid_in  input  49  current 7x7 grid; bit r*7+c is the cell at row r, column c; 1 = alive.
REQ-009 busy  output  1  high while a generation scan is in progress.
REQ-010 cell_idx  output  6  index of the cell being evaluated (0..48).
REQ-011 commit  output  1  one-cycle pulse; grid_next holds a new generation.
REQ-012 grid_next  output  49  most recently computed generation.
REQ-013 gen_count  output  GEN_W  number of committed generations.
REQ-014 stable  output  1  last committed generation equals its predecessor.
REQ-015 extinct  output  1  last committed generation has no live cells.

Function
REQ-016 The FSM SHALL have three states: WAIT, SCAN and COMMIT.
REQ-017 In WAIT, the wait counter SHALL increment each cycle; in RUN, the FSM SHALL enter SCAN on the cycle after the counter equals period.
REQ-018 In PAUSE, a step rising edge (step=1 with previous-cycle step=0) SHALL start SCAN on the next cycle; the wait counter is ignored.
REQ-019 Step edges SHALL be ignored in every mode except PAUSE; step held high SHALL yield exactly one generation.
REQ-020 On entry to SCAN, grid_in SHALL be latched into a snapshot; later grid_in changes SHALL NOT affect the scan in progress.
REQ-021 SCAN SHALL evaluate one cell per cycle, cell_idx 0 through 48 ascending, for exactly 49 cycles with busy=1.
REQ-022 Neighbour count SHALL use the 8 surrounding snapshot cells; out-of-grid positions are dead (no wrap-around).
REQ-023 The next-state rule SHALL be: alive if count==3, or if the cell is alive and count==2; otherwise dead.
REQ-024 Results SHALL accumulate in a shadow buffer; grid_next SHALL NOT change during SCAN.
REQ-025 After cell 48, the FSM SHALL spend one COMMIT cycle in which the shadow buffer is copied to grid_next, commit=1, gen_count increments modulo 2^GEN_W, stable=(shadow==snapshot) and extinct=(shadow==0).
REQ-026 From COMMIT, the FSM SHALL return to WAIT with the wait counter cleared; generation spacing in RUN SHALL be period+51 cycles.
REQ-027 If game_state changes to PAUSE during SCAN, the scan SHALL complete and commit normally.
REQ-028 If game_state is IDLE or PROGRAM in any cycle, the FSM SHALL go to WAIT with no commit, the wait counter cleared, gen_count, stable and extinct cleared, and grid_next unchanged.
REQ-029 cell_idx SHALL be 0 outside SCAN; busy SHALL be 0 in WAIT and COMMIT.

Reset
REQ-030 While rst_n=0 at a clka edge, the FSM SHALL go to WAIT and the wait counter and step history SHALL be cleared.
REQ-031 Reset values: busy=0, cell_idx=0, commit=0, grid_next=0, gen_count=0, stable=0, extinct=0.
REQ-032 Reset asserted mid-SCAN SHALL abort the scan with no commit pulse.

Verification
REQ-033 Blinker: RUN, period=0, grid_in=0x3800000 (bits 23,24,25) -> first commit 51 cycles after leaving reset, grid_next=0x81020000, stable=0, extinct=0, gen_count=1.
REQ-034 Still block: grid_in=0x183 -> grid_next=0x183, stable=1, extinct=0 at every commit.
REQ-035 Lone cell: grid_in=1<<24 -> grid_next=0, extinct=1, stable=0.
REQ-036 Step: PAUSE, step held high 100 cycles -> exactly one commit pulse; gen_count 0->1.
REQ-037 Abort: RUN, switch to PROGRAM at cell_idx=20 -> no commit, busy=0 next cycle, gen_count=0, grid_next unchanged.
REQ-038 Spacing: RUN, period=9 -> commit pulses exactly 60 cycles apart; grid_in changed mid-scan does not alter that generation's result.
